// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package onehot_dec_pkg;

    // Accepted-code counter width; the counter wraps silently.
    localparam int COUNT_W    = 8;

    // Widest supported code and the matching one-hot width.
    localparam int MAX_CODE_W = 4;
    localparam int MAX_OUT_W  = 1 << MAX_CODE_W;

    // Sequencer states. Prefixed so they cannot clash with the GAP parameter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } dec_state_e;

    // Binary index to one-hot line at the widest supported size.
    // Callers truncate to their own OUT_W.
    function automatic logic [MAX_OUT_W-1:0] to_onehot(input logic [MAX_CODE_W-1:0] code);
        logic [MAX_OUT_W-1:0] line;
        line       = '0;
        line[code] = 1'b1;
        return line;
    endfunction

    // Timer width: clog2(max(hold, gap, 2)).
    // This width always holds hold-1 and gap-1.
    function automatic int timer_width(input int hold, input int gap);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (m < 2)   m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/onehot_decoder_if.sv
// Code-in / one-hot-out bundle between a code source and the decoder.
// Latency: n/a (wires only).
// Backpressure: code_valid/code_ready handshake; the source holds code until accepted.
interface onehot_decoder_if
    import onehot_dec_pkg::*;
#(
    parameter int CODE_W = 2
) ();
    localparam int OUT_W = 2 ** CODE_W;

    logic               code_valid;
    logic [CODE_W-1:0]  code;
    logic               code_ready;
    logic [OUT_W-1:0]   onehot;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] count;

    // Code source side.
    modport master (
        output code_valid, code,
        input  code_ready, onehot, busy, done, count
    );

    // Decoder side.
    modport slave (
        input  code_valid, code,
        output code_ready, onehot, busy, done, count
    );
endinterface

// File: rtl/onehot_decoder_timer.sv
// Loadable down-counter with a zero flag, shared by the hold and gap phases.
// Latency: a load or decrement is visible the cycle after the edge that applies it.
// Backpressure: none; counting stops at zero rather than wrapping.
module dec_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins over decrement, and the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/onehot_decoder.sv
// Sequenced decoder: accepts a binary code, drives the matching one-hot line for HOLD cycles,
// then drives all-zero for GAP cycles. Latency: onehot appears one cycle after the accept edge.
// Backpressure: code_ready is low in DRIVE and GAP; the next accept comes HOLD+GAP+1 cycles later.
module onehot_decoder
    import onehot_dec_pkg::*;
#(
    parameter int CODE_W = 2,
    parameter int OUT_W  = 2 ** CODE_W,
    parameter int HOLD   = 4,
    parameter int GAP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    onehot_decoder_if.slave    bus
);

    // Reject unsupported configurations at elaboration.
    generate
        if ((CODE_W < 1) || (CODE_W > MAX_CODE_W)) begin : g_bad_code_w
            $error("onehot_decoder: CODE_W must be in 1..4");
        end
        if (OUT_W != (2 ** CODE_W)) begin : g_bad_out_w
            $error("onehot_decoder: OUT_W is derived from CODE_W and must not be overridden");
        end
        if (HOLD < 1) begin : g_bad_hold
            $error("onehot_decoder: HOLD must be at least 1");
        end
        if (GAP < 0) begin : g_bad_gap
            $error("onehot_decoder: GAP must not be negative");
        end
    endgenerate

    localparam int                  TIMER_W   = timer_width(HOLD, GAP);
    localparam logic [TIMER_W-1:0]  HOLD_LOAD = TIMER_W'(HOLD - 1);
    localparam logic [TIMER_W-1:0]  GAP_LOAD  = TIMER_W'((GAP > 0) ? (GAP - 1) : 0);

    dec_state_e          state_q;
    dec_state_e          state_d;
    logic [OUT_W-1:0]    onehot_q;
    logic [OUT_W-1:0]    onehot_d;
    logic                done_q;
    logic                done_d;
    logic [COUNT_W-1:0]  count_q;
    logic [COUNT_W-1:0]  count_d;

    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_load_val;
    logic                tmr_dec;
    logic                tmr_zero;

    logic [MAX_CODE_W-1:0] code_ext;
    logic                  xfer;

    // The same timer counts both the hold phase and the gap phase.
    // Every state change reloads it, so it never has to wrap.
    dec_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Widen the incoming code to the helper's fixed width.
    always_comb begin
        code_ext               = '0;
        code_ext[CODE_W-1:0]   = bus.code;
    end

    // Ready depends only on state, so there is no valid-to-ready combinational path.
    assign xfer = bus.code_valid && (state_q == ST_IDLE);

    // Next-state logic: accept in IDLE, hold the pattern in DRIVE, idle the line in GAP.
    always_comb begin
        state_d      = state_q;
        onehot_d     = onehot_q;
        done_d       = 1'b0;
        count_d      = count_q;
        tmr_load     = 1'b0;
        tmr_load_val = HOLD_LOAD;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                onehot_d = '0;
                if (xfer) begin
                    // The registered pattern is the latched code.
                    onehot_d     = OUT_W'(to_onehot(code_ext));
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                    count_d      = count_q + COUNT_W'(1);
                    state_d      = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (tmr_zero) begin
                    // End of hold: clear the line and pulse done.
                    // The done pulse overlaps the first gap cycle,
                    // or the first idle cycle when GAP is 0.
                    onehot_d = '0;
                    done_d   = 1'b1;
                    if (GAP > 0) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = GAP_LOAD;
                        state_d      = ST_GAP;
                    end else begin
                        state_d      = ST_IDLE;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_GAP: begin
                onehot_d = '0;
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            default: begin
                onehot_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    // Reset clears everything at once, so an interrupted pattern never reports done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            onehot_q <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign bus.code_ready = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.onehot     = onehot_q;
    assign bus.done       = done_q;
    assign bus.count      = count_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Bench for onehot_decoder: default instance (HOLD=4, GAP=1) and corner instance (HOLD=1, GAP=0).
// Reference model tracks the cycle index since each accept and derives outputs arithmetically.
// Sources hold code_valid/code until the model says the code was accepted.
module tb_onehot_decoder;

    localparam int CW     = 2;
    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int HOLD_B = 1;
    localparam int GAP_B  = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    onehot_decoder_if #(.CODE_W(CW)) ifa ();
    onehot_decoder_if #(.CODE_W(CW)) ifb ();

    onehot_decoder #(.CODE_W(CW), .HOLD(HOLD_A), .GAP(GAP_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    onehot_decoder #(.CODE_W(CW), .HOLD(HOLD_B), .GAP(GAP_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    // Model state per instance.
    // k_m: cycles since the last accept; 0 means no accept since reset.
    int k_m [2];
    int code_m [2];
    int cnt_m [2];
    int done_seen [2];
    int n_cmp = 0;
    int n_err = 0;
    int step_no = 0;
    logic xa, xb;
    logic [CW-1:0] seq_q [$];
    int last_xfer_step;

    function automatic int hold_of(input int d);
        return (d == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic logic [31:0] exp_onehot(input int d);
        if (k_m[d] >= 1 && k_m[d] <= hold_of(d)) return 32'd1 << code_m[d];
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_busy(input int d);
        return (k_m[d] >= 1 && k_m[d] <= hold_of(d) + gap_of(d)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_done(input int d);
        return (k_m[d] == hold_of(d) + 1) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic exp_ready(input int d);
        return !(k_m[d] >= 1 && k_m[d] <= hold_of(d) + gap_of(d));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_vs_model(input int d, input string p, input logic [31:0] oh,
                                  input logic [31:0] rdy, input logic [31:0] bsy,
                                  input logic [31:0] dn, input logic [31:0] cnt,
                                  input int ones);
        chk({p, "_onehot"}, oh, exp_onehot(d));
        chk({p, "_ready"}, rdy, {31'd0, exp_ready(d)});
        chk({p, "_busy"}, bsy, exp_busy(d));
        chk({p, "_done"}, dn, exp_done(d));
        chk({p, "_count"}, cnt, 32'(cnt_m[d]));
        chk({p, "_not_multihot"}, {31'd0, (ones <= 1)}, 32'd1);
        if (dn === 32'd1) done_seen[d]++;
    endtask

    task automatic check_both();
        check_vs_model(0, "a", 32'(ifa.onehot), 32'(ifa.code_ready), 32'(ifa.busy),
                       32'(ifa.done), 32'(ifa.count), $countones(ifa.onehot));
        check_vs_model(1, "b", 32'(ifb.onehot), 32'(ifb.code_ready), 32'(ifb.busy),
                       32'(ifb.done), 32'(ifb.count), $countones(ifb.onehot));
    endtask

    task automatic advance(input int d, input logic t, input logic [CW-1:0] c);
        if (t) begin
            k_m[d]    = 1;
            code_m[d] = int'(c);
            cnt_m[d]  = (cnt_m[d] + 1) % 256;
        end else if (k_m[d] != 0 && k_m[d] < 1000) begin
            k_m[d]++;
        end
    endtask

    // One cycle, entered and left at the falling edge:
    // drive inputs, check outputs, take the rising edge, update the model.
    task automatic step(input logic va, input logic [CW-1:0] ca,
                        input logic vb, input logic [CW-1:0] cb);
        ifa.code_valid = va;
        ifa.code       = ca;
        ifb.code_valid = vb;
        ifb.code       = cb;
        check_both();
        xa = va && exp_ready(0);
        xb = vb && exp_ready(1);
        @(posedge clk);
        advance(0, xa, ca);
        advance(1, xb, cb);
        step_no++;
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    // Present seq_q on instance A with valid held until each code is accepted.
    // Checks that accepts are exactly one period apart.
    task automatic drive_seq_a(input int max_steps);
        int first;
        first = 1;
        for (int i = 0; i < max_steps && seq_q.size() > 0; i++) begin
            step(1'b1, seq_q[0], 1'b0, '0);
            if (xa) begin
                if (!first) chk("a_period", 32'(step_no - last_xfer_step), 32'(HOLD_A + GAP_A + 1));
                first          = 0;
                last_xfer_step = step_no;
                void'(seq_q.pop_front());
            end
        end
        chk("a_seq_drained", 32'(seq_q.size()), 32'd0);
    endtask

    initial begin
        logic          pend;
        logic [CW-1:0] pc;
        int            nx;
        int            nsteps;

        for (int d = 0; d < 2; d++) begin
            k_m[d]       = 0;
            code_m[d]    = 0;
            cnt_m[d]     = 0;
            done_seen[d] = 0;
        end
        rst_n          = 1'b0;
        ifa.code_valid = 1'b0;
        ifa.code       = '0;
        ifb.code_valid = 1'b0;
        ifb.code       = '0;

        // Reset values, observed before any clock edge.
        #1;
        check_both();
        @(negedge clk);
        rst_n = 1'b1;
        idle_steps(2);

        // Single code 2, valid for one cycle.
        done_seen[0] = 0;
        step(1'b1, 2'd2, 1'b0, '0);
        chk("single_accepted", {31'd0, xa}, 32'd1);
        idle_steps(8);
        chk("single_done_pulses", 32'(done_seen[0]), 32'd1);
        chk("single_count", 32'(ifa.count), 32'd1);

        // Back-to-back codes 0..3 with valid held high.
        done_seen[0] = 0;
        seq_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        drive_seq_a(60);
        idle_steps(8);
        chk("b2b_done_pulses", 32'(done_seen[0]), 32'd4);
        chk("b2b_count", 32'(ifa.count), 32'd5);

        // Backpressure: code 3 waits behind code 1.
        seq_q = '{2'd1, 2'd3};
        drive_seq_a(60);
        idle_steps(8);

        // Reset during the second DRIVE cycle of code 1.
        done_seen[0] = 0;
        step(1'b1, 2'd1, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        chk("mid_pre_onehot", 32'(ifa.onehot), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            k_m[d]   = 0;
            cnt_m[d] = 0;
        end
        chk("mid_rst_onehot", 32'(ifa.onehot), 32'd0);
        chk("mid_rst_count", 32'(ifa.count), 32'd0);
        chk("mid_rst_busy", 32'(ifa.busy), 32'd0);
        check_both();
        done_seen[0] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_steps(8);
        chk("mid_rst_no_done", 32'(done_seen[0]), 32'd0);
        chk("mid_rst_ready", 32'(ifa.code_ready), 32'd1);

        // Randomized traffic on A; each code is held until accepted.
        pend = 1'b0;
        pc   = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pc   = CW'($urandom_range(0, 3));
            end
            step(pend, pc, 1'b0, '0);
            if (xa) pend = 1'b0;
        end
        idle_steps(8);

        // Corner instance: continuous valid, 2-cycle period, count wraps after 256 accepts.
        nx     = 0;
        nsteps = 0;
        while (nx < 256 && nsteps < 700) begin
            step(1'b0, '0, 1'b1, CW'($urandom_range(0, 3)));
            nsteps++;
            if (xb) nx++;
        end
        chk("wrap_transfers", 32'(nx), 32'd256);
        chk("wrap_steps", 32'(nsteps), 32'd511);
        chk("wrap_count", 32'(ifb.count), 32'd0);
        idle_steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
